mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core subset.
- Produces the 2-bit alu_op consumed by the ALU control decoder, plus all datapath mux selects and write strobes.
- Steps each instruction through Fetch/Decode/Execute/Writeback.
- Stalls on a memory-ready handshake and traps on unsupported opcodes.

Parameters:
- STATE_W, 4, width of the state register and the debug state port.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  7  instruction[6:0] from instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  unified memory completes the current access this cycle
- alu_op  output  2  00 add, 01 sub, 10 funct-decode
- alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4
- result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
- imm_src  output  2  00 I, 01 S, 10 B, 11 J (combinational from op)
- adr_src  output  1  0 PC, 1 Result
- ir_write  output  1  load IR/OldPC
- pc_write  output  1  load PC
- mem_write  output  1  memory write request
- reg_write  output  1  register file write
- illegal  output  1  sticky trap flag
- state  output  STATE_W  current state, debug only

Behaviour:
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- States (encoding 0..10):
  - FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
  - TRAP = 11
- Transitions:
  - FETCH -> DECODE when mem_ready, else hold.
  - DECODE by op: lw/sw -> MEMADR; R -> EXECR; I-ALU -> EXECI; beq -> BEQ; jal -> JAL; other -> TRAP.
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD -> MEMWB when mem_ready, else hold.
  - MEMWRITE -> FETCH when mem_ready, else hold.
  - MEMWB, BEQ -> FETCH.
  - EXECR, EXECI, JAL -> ALUWB; ALUWB -> FETCH.
  - TRAP holds until reset.
- Outputs per state (unlisted fields are 0):
  - FETCH: src_a 00, src_b 10, alu_op 00, result_src 10, adr_src 0. ir_write = pc_update = mem_ready.
  - DECODE: src_a 01, src_b 01, alu_op 00 (precomputes branch target).
  - MEMADR: src_a 10, src_b 01, alu_op 00.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1 for every cycle in the state.
  - EXECR: src_a 10, src_b 00, alu_op 10.
  - EXECI: src_a 10, src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: src_a 10, src_b 00, alu_op 01, result_src 00, branch 1.
  - JAL: src_a 01, src_b 10, alu_op 00, result_src 00, pc_update 1.
  - TRAP: all strobes 0, illegal 1.
- pc_write = pc_update | (branch & zero). This is the only output combinational in zero; all others are functions of state (and mem_ready in FETCH) only.
- imm_src decodes op independently of state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- Latency with mem_ready held 1:
  - R / I-ALU / sw / jal: 4 cycles
  - lw: 5 cycles
  - beq: 3 cycles
  - Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Reset:
  - rst_n low forces state=FETCH and illegal=0 immediately, asynchronously.
  - While rst_n is low, ir_write, pc_write, mem_write and reg_write are forced 0.
  - Reset mid-instruction abandons it; no strobe fires in the reset cycle.
  - First FETCH strobe occurs on the first edge after deassertion with mem_ready=1.
- mem_ready in non-memory states is ignored.
- zero is sampled only in BEQ.
- op is only meaningful from DECODE onward; the IR is stable after FETCH.
- illegal stays set until reset.

Test Plan:
- Reset, then R-type add (op=0110011, mem_ready=1): states 0,1,6,8,0.
  - alu_op=10 in EXECR.
  - reg_write=1 only in ALUWB.
  - pc_write=1 only in the FETCH cycle.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD: 10 cycles total.
  - ir_write pulses exactly once.
  - reg_write with result_src=01 exactly once.
- sw, then beq with zero=1, then beq with zero=0:
  - mem_write high throughout MEMWRITE.
  - In BEQ, alu_op=01; pc_write=1 only in the zero=1 case.
  - Each beq takes 3 cycles.
- jal (op=1101111):
  - JAL state: src_a=01, src_b=10, pc_write=1, imm_src=11.
  - ALUWB writes the register.
  - Total 4 cycles.
- Illegal op 1111111 in DECODE: next state TRAP, illegal=1.
  - All strobes 0 for 20 cycles.
  - rst_n pulse clears illegal and returns to FETCH.
- rst_n asserted mid-MEMWRITE while mem_ready=0: state=FETCH and mem_write=0 asynchronously, with no write strobe after release until a new sw.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multi-cycle RV32I subset main control FSM
module mc_main_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         alu_op,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Enumeration order fixes the encoding: FETCH=0 .. JAL=10, TRAP=11.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t state_q, state_d;
    logic   ir_w, pc_update, branch, mem_w, reg_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_w       = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_w       = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Strobes are gated by rst_n so nothing fires while reset is held.
    assign ir_write  = ir_w & rst_n;
    assign pc_write  = (pc_update | (branch & zero)) & rst_n;
    assign mem_write = mem_w & rst_n;
    assign reg_write = reg_w & rst_n;
    assign illegal   = (state_q == S_TRAP);
    assign state     = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - randomized bench for mc_main_ctrl against a per-instruction state-sequence model
module tb_mc_main_ctrl;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
    localparam int EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    localparam logic [13:0] STROBES = 14'h001E;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero, mem_ready;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src, imm_src;
    logic       adr_src, ir_write, pc_write, mem_write, reg_write, illegal;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    mc_main_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .mem_write(mem_write),
        .reg_write(reg_write), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // {alu_op, src_a, src_b, result_src, adr_src, ir_write, pc_write, mem_write, reg_write, illegal}
    function automatic logic [13:0] exp_ctrl(int st, bit mr, bit z);
        logic [1:0] aop = 0, sa = 0, sb = 0, rs = 0;
        bit adr = 0, irw = 0, pcw = 0, mw = 0, rw = 0, ill = 0;
        case (st)
            FETCH:    begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            DECODE:   begin sa = 1; sb = 1; end
            MEMADR:   begin sa = 2; sb = 1; end
            MEMREAD:  adr = 1;
            MEMWB:    begin rs = 1; rw = 1; end
            MEMWRITE: begin adr = 1; mw = 1; end
            EXECR:    begin sa = 2; aop = 2; end
            EXECI:    begin sa = 2; sb = 1; aop = 2; end
            ALUWB:    rw = 1;
            BEQ:      begin sa = 2; aop = 1; pcw = z; end
            JAL:      begin sa = 1; sb = 2; pcw = 1; end
            default:  ill = 1;
        endcase
        return {aop, sa, sb, rs, adr, irw, pcw, mw, rw, ill};
    endfunction

    function automatic logic [1:0] exp_imm(logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [13:0] obs_ctrl();
        return {alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
                pc_write, mem_write, reg_write, illegal};
    endfunction

    // One clock cycle: drive inputs at negedge, check outputs shortly after.
    task automatic step(input int st, input bit mr, input bit z);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        #1;
        chk("state", 32'(state), 32'(st));
        chk("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(st, mr, z)));
        chk("imm_src", 32'(imm_src), 32'(exp_imm(op)));
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [6:0] o, input int kf, input int km, input bit z);
        op = o;
        repeat (kf) step(FETCH, 0, rb());
        step(FETCH, 1, rb());
        step(DECODE, rb(), rb());
        case (o)
            OP_LW: begin
                step(MEMADR, rb(), rb());
                repeat (km) step(MEMREAD, 0, rb());
                step(MEMREAD, 1, rb());
                step(MEMWB, rb(), rb());
            end
            OP_SW: begin
                step(MEMADR, rb(), rb());
                repeat (km) step(MEMWRITE, 0, rb());
                step(MEMWRITE, 1, rb());
            end
            OP_R:   begin step(EXECR, rb(), rb()); step(ALUWB, rb(), rb()); end
            OP_I:   begin step(EXECI, rb(), rb()); step(ALUWB, rb(), rb()); end
            OP_BEQ: step(BEQ, rb(), z);
            OP_JAL: begin step(JAL, rb(), rb()); step(ALUWB, rb(), rb()); end
            default: repeat (20) step(TRAP, rb(), rb());
        endcase
    endtask

    // Reset is asserted mid-cycle; mem_ready=1 during reset proves the FETCH strobes are gated.
    task automatic reset_pulse();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'(FETCH));
        chk("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(FETCH, 1, 1) & ~STROBES));
        @(negedge clk);
        #1;
        chk("rst_hold_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(FETCH, 1, 1) & ~STROBES));
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    initial begin
        rst_n = 1'b0;
        op = OP_R;
        zero = 1'b0;
        mem_ready = 1'b0;
        #2;
        reset_pulse();

        run_instr(OP_R, 0, 0, 0);
        run_instr(OP_LW, 2, 3, 0);
        run_instr(OP_SW, 0, 2, 0);
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_JAL, 0, 0, 0);
        run_instr(OP_I, 1, 0, 0);

        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                      $urandom_range(0, 3), rb());

        // Abandon a store while memory is stalled.
        op = OP_SW;
        step(FETCH, 1, 0);
        step(DECODE, 1, 0);
        step(MEMADR, 1, 0);
        step(MEMWRITE, 0, 0);
        step(MEMWRITE, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'(FETCH));
        chk("mid_rst_mem_write", 32'(mem_write), 32'(0));
        reset_pulse();
        run_instr(OP_R, 1, 0, 0);
        run_instr(OP_SW, 0, 1, 0);

        run_instr(OP_BAD, 0, 0, 0);
        #2;
        reset_pulse();
        chk("post_trap_illegal", 32'(illegal), 32'(0));
        run_instr(OP_LW, 0, 0, 0);
        run_instr(OP_BEQ, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
